mii_tx_scheduler: RTL and testbench

Round-robin scheduler that shares the single 64-bit/8-lane MII transmit datapath between N_REQ frame sources. It grants one source at a time and frames the source's payload words with START, preamble/SFD, TERMINATE and IDLE fill. It enforces a minimum inter-frame gap and flags source underruns. It sits between the per-source frame buffers and the PCS transmit interface, and drives the same o_tx_data/o_tx_ctrl lane format as the traffic generator.

---
 rtl/mii_pkg.sv | 42 ++++
 rtl/mii_tx_scheduler_if.sv | 28 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/mii_tx_scheduler.sv | 126 ++++++++++++
 tb/tb_mii_tx_scheduler.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mii_pkg.sv
// Shared MII control codes, fixed framing words and the FSM state type.
// Pure declarations, no timing; no backpressure.
package mii_pkg;

  localparam logic [7:0] IDLE_CODE  = 8'h07;
  localparam logic [7:0] START_CODE = 8'hFB;
  localparam logic [7:0] TERM_CODE  = 8'hFD;
  localparam logic [7:0] ERROR_CODE = 8'hFE;
  localparam int         LANES      = 8;

  localparam logic [63:0] IDLE_WORD  = {8{IDLE_CODE}};
  localparam logic [63:0] START_WORD = {8'hD5, {6{8'h55}}, START_CODE};
  localparam logic [63:0] ERROR_WORD = {8{ERROR_CODE}};
  localparam logic [63:0] TERM_WORD  = {{7{IDLE_CODE}}, TERM_CODE};

  typedef enum logic [1:0] {IDLE, PAYLOAD, TERM, IFG} state_t;

  // 0 and anything above 8 mean a full last word
  function automatic logic [3:0] norm_nbytes(logic [3:0] nbytes);
    return (nbytes == 4'd0 || nbytes > 4'd8) ? 4'd8 : nbytes;
  endfunction

  function automatic logic [71:0] term_word(logic [63:0] data, logic [3:0] nbytes);
    logic [63:0] d;
    logic [7:0]  c;
    int          n;
    n = int'(norm_nbytes(nbytes));
    d = data;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i == n) begin
        d[i*8 +: 8] = TERM_CODE;
        c[i]        = 1'b1;
      end else if (i > n) begin
        d[i*8 +: 8] = IDLE_CODE;
        c[i]        = 1'b1;
      end
    end
    return {d, c};
  endfunction

endpackage

// File: rtl/mii_tx_scheduler_if.sv
// Source-side request bundle and PCS-side MII outputs of the scheduler.
// master = frame sources / PCS observer, slave = scheduler.
interface mii_tx_scheduler_if #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
);
  logic [N_REQ-1:0]            i_req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [N_REQ-1:0]            i_req_last;
  logic [N_REQ*4-1:0]          i_req_nbytes;
  logic [N_REQ-1:0]            o_req_ready;
  logic [N_REQ-1:0]            o_grant;
  logic [DATA_WIDTH-1:0]       o_tx_data;
  logic [CTRL_WIDTH-1:0]       o_tx_ctrl;
  logic                        o_busy;
  logic                        o_underrun;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_req_nbytes,
    input  o_req_ready, o_grant, o_tx_data, o_tx_ctrl, o_busy, o_underrun
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_req_nbytes,
    output o_req_ready, o_grant, o_tx_data, o_tx_ctrl, o_busy, o_underrun
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
// Zero latency; no backpressure, caller decides when to latch the result.
module rr_arbiter
  import mii_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant_onehot,
  output logic [IDX_W-1:0] o_grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    o_grant_onehot = '0;
    o_grant_idx    = '0;
    found          = 1'b0;
    idx            = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(i_ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && i_req[idx]) begin
        found               = 1'b1;
        o_grant_onehot[idx] = 1'b1;
        o_grant_idx         = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mii_tx_scheduler.sv
// Shares one 64b MII tx path between N_REQ sources: start, payload, terminate, IFG.
// Word accepted at edge k shows on o_tx after k; ready only to the owner in PAYLOAD.
module mii_tx_scheduler
  import mii_pkg::*;
#(
  parameter  int N_REQ      = 2,
  parameter  int DATA_WIDTH = 64,
  parameter  int CTRL_WIDTH = 8,
  parameter  int IFG_CYCLES = 1,
  localparam int IDX_W      = $clog2(N_REQ)
) (
  input logic               clk,
  input logic               i_rst_n,
  mii_tx_scheduler_if.slave bus
);

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      ptr, ptr_nxt, gidx, gidx_nxt, arb_idx;
  logic [N_REQ-1:0]      grant, grant_nxt, arb_onehot;
  logic [DATA_WIDTH-1:0] tx_data, tx_data_nxt, cur_data;
  logic [CTRL_WIDTH-1:0] tx_ctrl, tx_ctrl_nxt;
  logic                  busy, busy_nxt, underrun, underrun_nxt;
  logic [3:0]            ifg_cnt, ifg_cnt_nxt, cur_nb;
  logic                  cur_valid, cur_last;
  logic [71:0]           tail;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req          (bus.i_req_valid),
    .i_ptr          (ptr),
    .o_grant_onehot (arb_onehot),
    .o_grant_idx    (arb_idx)
  );

  assign cur_valid = bus.i_req_valid[gidx];
  assign cur_last  = bus.i_req_last[gidx];
  assign cur_data  = bus.i_req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign cur_nb    = bus.i_req_nbytes[int'(gidx)*4 +: 4];
  assign tail      = term_word(cur_data, cur_nb);

  // ready comes from registered state only, never from valid
  assign bus.o_req_ready = (state == PAYLOAD) ? grant : '0;
  assign bus.o_grant     = grant;
  assign bus.o_tx_data   = tx_data;
  assign bus.o_tx_ctrl   = tx_ctrl;
  assign bus.o_busy      = busy;
  assign bus.o_underrun  = underrun;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gidx     <= '0;
      grant    <= '0;
      tx_data  <= IDLE_WORD;
      tx_ctrl  <= '1;
      busy     <= 1'b0;
      underrun <= 1'b0;
      ifg_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gidx     <= gidx_nxt;
      grant    <= grant_nxt;
      tx_data  <= tx_data_nxt;
      tx_ctrl  <= tx_ctrl_nxt;
      busy     <= busy_nxt;
      underrun <= underrun_nxt;
      ifg_cnt  <= ifg_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    gidx_nxt     = gidx;
    grant_nxt    = grant;
    tx_data_nxt  = IDLE_WORD;
    tx_ctrl_nxt  = '1;
    busy_nxt     = busy;
    underrun_nxt = 1'b0;
    ifg_cnt_nxt  = ifg_cnt;
    case (state)
      IDLE: begin
        // grant/busy track o_tx, so they drop only once the last IFG word has shown
        grant_nxt = arb_onehot;
        busy_nxt  = |bus.i_req_valid;
        if (|bus.i_req_valid) begin
          tx_data_nxt = START_WORD;
          tx_ctrl_nxt = CTRL_WIDTH'(8'h01);
          gidx_nxt    = arb_idx;
          ptr_nxt     = (arb_idx == IDX_W'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
          state_nxt   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!cur_valid) begin
          tx_data_nxt  = ERROR_WORD;
          underrun_nxt = 1'b1;
        end else if (!cur_last) begin
          tx_data_nxt = cur_data;
          tx_ctrl_nxt = '0;
        end else if (norm_nbytes(cur_nb) == 4'd8) begin
          tx_data_nxt = cur_data;
          tx_ctrl_nxt = '0;
          state_nxt   = TERM;
        end else begin
          tx_data_nxt = tail[71:8];
          tx_ctrl_nxt = tail[7:0];
          ifg_cnt_nxt = '0;
          state_nxt   = IFG;
        end
      end
      TERM: begin
        tx_data_nxt = TERM_WORD;
        ifg_cnt_nxt = '0;
        state_nxt   = IFG;
      end
      IFG: begin
        ifg_cnt_nxt = ifg_cnt + 4'd1;
        if (ifg_cnt == 4'(IFG_CYCLES-1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mii_tx_scheduler.sv
// Frame-level reference: expected o_tx stream is built per frame list and RR order,
// then compared word by word against the DUT.
module tb_mii_tx_scheduler;

  localparam int N    = 3;
  localparam int IFG  = 2;
  localparam int MAXF = 6;
  localparam int MAXW = 8;

  localparam logic [63:0] W_IDLE  = 64'h0707070707070707;
  localparam logic [63:0] W_START = 64'hD5555555555555FB;
  localparam logic [63:0] W_TERM  = 64'h07070707070707FD;
  localparam logic [63:0] W_ERR   = 64'hFEFEFEFEFEFEFEFE;

  typedef struct packed {
    logic [63:0]  data;
    logic [7:0]   ctrl;
    logic         busy;
    logic         ur;
    logic [N-1:0] grant;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mii_tx_scheduler_if #(.N_REQ(N), .DATA_WIDTH(64), .CTRL_WIDTH(8)) bus ();

  mii_tx_scheduler #(.N_REQ(N), .DATA_WIDTH(64), .CTRL_WIDTH(8), .IFG_CYCLES(IFG)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [63:0] fdat  [N][MAXF][MAXW];
  int          flen  [N][MAXF];
  logic [3:0]  fnb   [N][MAXF];
  int          fgpos [N][MAXF];
  int          fglen [N][MAXF];
  int          nfr   [N];
  int          fi [N], wi [N], gcnt [N];
  int          mptr;
  obs_t        expq [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clear_frames();
    for (int s = 0; s < N; s++) nfr[s] = 0;
  endtask

  task automatic add_frame(input int s, input int len, input logic [3:0] nb,
                           input int gpos, input int glen);
    int f;
    f = nfr[s];
    flen[s][f]  = len;
    fnb[s][f]   = nb;
    fgpos[s][f] = gpos;
    fglen[s][f] = glen;
    for (int w = 0; w < len; w++) fdat[s][f][w] = {$urandom(), $urandom()};
    nfr[s] = f + 1;
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] c, input logic b,
                      input logic u, input logic [N-1:0] g);
    expq.push_back({d, c, b, u, g});
  endtask

  // Whole-stream prediction: every source keeps valid up while it has frames,
  // so each start word goes to the next source in RR order that still has work.
  task automatic build_expected();
    int rem [N];
    int fc  [N];
    int own, f, n, len;
    logic [N-1:0] g;
    logic [63:0]  d;
    logic [7:0]   c;
    logic [63:0]  w;
    expq.delete();
    for (int s = 0; s < N; s++) begin rem[s] = nfr[s]; fc[s] = 0; end
    for (int k = 0; k < 64; k++) begin
      own = -1;
      for (int off = 0; off < N; off++)
        if (own < 0 && rem[(mptr + off) % N] > 0) own = (mptr + off) % N;
      if (own < 0) break;
      mptr = (own + 1) % N;
      g = '0;
      g[own] = 1'b1;
      f   = fc[own];
      len = flen[own][f];
      push(W_START, 8'h01, 1'b1, 1'b0, g);
      for (int wd = 0; wd < len; wd++) begin
        if (wd > 0 && wd == fgpos[own][f])
          for (int e = 0; e < fglen[own][f]; e++) push(W_ERR, 8'hFF, 1'b1, 1'b1, g);
        w = fdat[own][f][wd];
        if (wd < len - 1) begin
          push(w, 8'h00, 1'b1, 1'b0, g);
        end else begin
          n = (fnb[own][f] == 0 || fnb[own][f] > 8) ? 8 : int'(fnb[own][f]);
          if (n == 8) begin
            push(w, 8'h00, 1'b1, 1'b0, g);
            push(W_TERM, 8'hFF, 1'b1, 1'b0, g);
          end else begin
            for (int L = 0; L < 8; L++) begin
              d[L*8 +: 8] = (L < n) ? w[L*8 +: 8] : ((L == n) ? 8'hFD : 8'h07);
              c[L]        = (L >= n);
            end
            push(d, c, 1'b1, 1'b0, g);
          end
        end
      end
      for (int e = 0; e < IFG; e++) push(W_IDLE, 8'hFF, 1'b1, 1'b0, g);
      fc[own]++;
      rem[own]--;
    end
    for (int e = 0; e < 3; e++) push(W_IDLE, 8'hFF, 1'b0, 1'b0, '0);
  endtask

  task automatic drive_all(input logic [N-1:0] fire);
    for (int s = 0; s < N; s++) begin
      if (fire[s]) begin
        wi[s]++;
        if (wi[s] == flen[s][fi[s]]) begin fi[s]++; wi[s] = 0; end
        gcnt[s] = 0;
        if (fi[s] < nfr[s] && wi[s] > 0 && wi[s] == fgpos[s][fi[s]]) gcnt[s] = fglen[s][fi[s]];
      end
      if (fi[s] < nfr[s]) begin
        bus.i_req_data[s*64 +: 64] = fdat[s][fi[s]][wi[s]];
        bus.i_req_last[s]          = (wi[s] == flen[s][fi[s]] - 1);
        bus.i_req_nbytes[s*4 +: 4] = fnb[s][fi[s]];
      end
      if (gcnt[s] > 0) begin
        bus.i_req_valid[s] = 1'b0;
        gcnt[s]--;
      end else begin
        bus.i_req_valid[s] = (fi[s] < nfr[s]);
      end
    end
  endtask

  task automatic run_scenario(input string name, input int abort_after);
    logic [N-1:0] fire;
    bit   started;
    int   popped;
    obs_t o, e;
    build_expected();
    for (int s = 0; s < N; s++) begin fi[s] = 0; wi[s] = 0; gcnt[s] = 0; end
    drive_all('0);
    started = 0;
    popped  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      o    = {bus.o_tx_data, bus.o_tx_ctrl, bus.o_busy, bus.o_underrun, bus.o_grant};
      fire = bus.i_req_valid & bus.o_req_ready;
      if (!started && o.ctrl == 8'h01) started = 1;
      if (!started) begin
        if (cyc >= 20) begin
          chk({name, ":start_timeout"}, 64'(o.ctrl), 64'h01);
          break;
        end
        chk({name, ":pre_idle"}, o.data, W_IDLE);
      end else begin
        e = expq.pop_front();
        chk({name, ":data"}, o.data, e.data);
        chk({name, ":ctrl"}, 64'(o.ctrl), 64'(e.ctrl));
        chk({name, ":busy_ur_grant"}, 64'({o.busy, o.ur, o.grant}), 64'({e.busy, e.ur, e.grant}));
        popped++;
        if (expq.size() == 0) break;
        if (abort_after > 0 && popped == abort_after) break;
      end
      @(posedge clk);
      #1;
      drive_all(fire);
    end
    if (abort_after == 0) chk({name, ":stream_done"}, 64'(expq.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, ":data"},  bus.o_tx_data, W_IDLE);
    chk({name, ":ctrl"},  64'(bus.o_tx_ctrl), 64'hFF);
    chk({name, ":ready"}, 64'(bus.o_req_ready), 64'd0);
    chk({name, ":grant"}, 64'(bus.o_grant), 64'd0);
    chk({name, ":busy"},  64'(bus.o_busy), 64'd0);
    chk({name, ":ur"},    64'(bus.o_underrun), 64'd0);
  endtask

  initial begin
    int len, gp, gl;
    rst_n            = 1'b0;
    bus.i_req_valid  = '0;
    bus.i_req_data   = '0;
    bus.i_req_last   = '0;
    bus.i_req_nbytes = '0;
    clear_frames();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    mptr  = 0;

    // directed: nbytes 3 tail, full-word TERM, underrun gap, nbytes 0
    clear_frames();
    add_frame(0, 3, 4'd3, 0, 0);
    fdat[0][0][2] = {8{8'hAA}};
    add_frame(0, 5, 4'd6, 2, 2);
    add_frame(1, 2, 4'd8, 0, 0);
    add_frame(1, 1, 4'd0, 0, 0);
    run_scenario("directed", 0);

    // two persistent requesters, single-word frames: alternating grants
    clear_frames();
    for (int k = 0; k < 4; k++) begin
      add_frame(0, 1, 4'($urandom_range(1, 8)), 0, 0);
      add_frame(1, 1, 4'($urandom_range(1, 8)), 0, 0);
    end
    run_scenario("alternate", 0);

    // single requester re-granted every frame
    clear_frames();
    for (int k = 0; k < 3; k++) add_frame(2, 2, 4'($urandom_range(0, 15)), 0, 0);
    run_scenario("solo", 0);

    // reset during source 1 payload, then fresh start from source 0
    clear_frames();
    add_frame(0, 2, 4'd5, 0, 0);
    add_frame(1, 8, 4'd8, 0, 0);
    run_scenario("pre_rst", 8);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    bus.i_req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("held_rst");
    rst_n = 1'b1;
    mptr  = 0;
    clear_frames();
    add_frame(0, 2, 4'd4, 0, 0);
    add_frame(1, 2, 4'd7, 0, 0);
    run_scenario("post_rst", 0);

    for (int r = 0; r < 6; r++) begin
      clear_frames();
      for (int s = 0; s < N; s++) begin
        for (int k = 0; k < ((s == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3)); k++) begin
          len = $urandom_range(1, 6);
          gp  = 0;
          gl  = 0;
          if (len > 1 && $urandom_range(0, 1) == 1) begin
            gp = $urandom_range(1, len - 1);
            gl = $urandom_range(1, 3);
          end
          add_frame(s, len, 4'($urandom_range(0, 15)), gp, gl);
        end
      end
      run_scenario($sformatf("rand%0d", r), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
